pdm_mic_frontend: RTL
=====================

Name: pdm_mic_frontend

Overview:
- Front-end stage for the on-board PDM microphone, sitting directly upstream of the clap detector.
- Generates the microphone clock and channel select.
- Synchronises and samples the 1-bit PDM stream, then decimates it by counting ones over a fixed window.
- Per window, produces a PCM level, an amplitude magnitude and a loudness flag, with a one-cycle valid strobe the detector consumes.

Parameters:
- CLK_DIV, 50, clk_i cycles per m_clk_o period; even, >= 4 (100 MHz / 50 = 2 MHz).
- WIN_LOG2, 8, log2 of PDM samples per window (default window = 256 samples).
- THRESH, 64, amplitude at or above which loud_o asserts; width WIN_LOG2.

Ports:
- clk_i  in  1  system clock (100 MHz).
- rst_ni  in  1  asynchronous reset, active-low.
- en_i  in  1  run enable; low freezes the microphone clock and clears window progress.
- m_data_i  in  1  raw PDM data from the microphone (asynchronous to clk_i).
- m_clk_o  out  1  microphone clock, registered.
- m_lrsel_o  out  1  channel select; constant 0 (data valid around the rising edge of m_clk_o).
- pcm_o  out  WIN_LOG2+1  ones count of the last completed window, range 0..2^WIN_LOG2.
- amp_o  out  WIN_LOG2  |pcm_o - 2^(WIN_LOG2-1)|, range 0..2^(WIN_LOG2-1).
- loud_o  out  1  amp_o >= THRESH.
- valid_o  out  1  one-cycle strobe; pcm_o, amp_o and loud_o updated in the same cycle.

Behaviour:
- Reset: asynchronous on rst_ni low. All registers clear: div_cnt, samp_cnt, ones, sync flops, pcm_o, amp_o. Output reset values are m_clk_o=0, loud_o=0, valid_o=0; m_lrsel_o is tied to 0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - m_clk_o is registered: 0 while div_cnt < CLK_DIV/2, 1 otherwise. Duty cycle is exactly 50%.
- Input sync: m_data_i passes through a 2-FF synchroniser before any use. This adds 2 clk_i cycles of latency, far below the half period.
- Sample strobe:
  - Asserted in the cycle where div_cnt == CLK_DIV-1, i.e. late in the high phase, just before the falling edge.
  - The synchronised bit is taken on that strobe.
  - Exactly one sample per m_clk_o period.
- Window accumulation:
  - On each strobe, ones += bit and samp_cnt += 1.
  - samp_cnt is WIN_LOG2 bits wide and wraps naturally.
  - ones is WIN_LOG2+1 bits wide and cannot overflow.
- Window close, on the strobe where samp_cnt == 2^WIN_LOG2-1:
  - Next cycle: pcm_o <= ones + bit, amp_o and loud_o are computed from that value, and valid_o=1 for exactly one cycle.
  - ones clears to 0 in the same cycle.
  - Latency is 1 clk_i cycle from the final strobe to valid_o.
- Amplitude: computed as an unsigned difference, taking the larger minus the smaller of pcm and 2^(WIN_LOG2-1). No saturation is needed.
- Output hold: outputs hold between strobes; valid_o is low at all other times.
- en_i low:
  - div_cnt, samp_cnt and ones clear; m_clk_o is forced to 0.
  - No strobe and no valid_o.
  - pcm_o, amp_o and loud_o keep their last values.
- en_i rising: a fresh window starts from div_cnt=0. No partial window is ever reported.
- Reset mid-window: all state is discarded. After release, the first valid_o arrives exactly 2^WIN_LOG2 * CLK_DIV cycles after the first enabled cycle (plus 1 cycle of output latency).
- Simultaneous events: a window close coinciding with en_i falling is dropped (en_i wins); no valid_o is issued.

Optional Feature:
- Macro: PDM_PEAK_HOLD_EN.
- Defined:
  - Adds output peak_o, width WIN_LOG2, reset 0.
  - On each valid_o: if amp_o_new > peak_o, then peak_o <= amp_o_new; else if peak_o > 0, peak_o decrements by 1.
  - peak_o holds while en_i is low.
- Undefined: port and logic are absent; behaviour otherwise identical.

Test Plan:
- Reset release with en_i=1 -> m_clk_o period 50 cycles (25 low / 25 high); m_lrsel_o=0; valid_o and loud_o stay 0 until the first window closes.
- m_data_i held 1 for a full window -> valid_o pulse; pcm_o=256, amp_o=128, loud_o=1; strobes recur every 12800 cycles.
- m_data_i alternating 1/0 per m_clk_o period -> pcm_o=128, amp_o=0, loud_o=0.
- Exactly 64 ones in a window -> pcm_o=64, amp_o=64, loud_o=1. Exactly 65 ones -> amp_o=63, loud_o=0.
- en_i dropped at sample 100 and raised 1000 cycles later -> m_clk_o stays 0, no valid_o, previous outputs held; first new valid_o comes 12800+1 cycles after re-enable.
- rst_ni pulsed low mid-window -> all outputs 0 immediately (asynchronously); next valid_o reports only post-reset samples. With PDM_PEAK_HOLD_EN: amplitudes 100, 40, 40 -> peak_o 100, 99, 98.

Source files
------------

// File: rtl/pdm_mic_frontend.sv
// ---------------------------------------------------------------------------
// pdm_mic_frontend
//
// Front end for the on-board PDM microphone. Generates the microphone clock,
// synchronises the 1-bit PDM stream, samples it once per microphone clock
// period and decimates it by counting ones over a window of 2^WIN_LOG2
// samples. Each completed window yields a PCM level, its distance from
// mid-scale (amplitude) and a loudness flag, qualified by a one-cycle strobe.
//
// Parameters:
//   CLK_DIV   clk_i cycles per m_clk_o period (even, >= 4)
//   WIN_LOG2  log2 of samples per window
//   THRESH    amplitude at or above which loud_o asserts
//
// Ports:
//   clk_i      in   system clock
//   rst_ni     in   asynchronous reset, active low
//   en_i       in   run enable; low stops m_clk_o and discards window progress
//   m_data_i   in   raw PDM data (asynchronous to clk_i)
//   m_clk_o    out  microphone clock, registered, 50% duty
//   m_lrsel_o  out  channel select, tied low
//   pcm_o      out  ones count of the last completed window (0..2^WIN_LOG2)
//   amp_o      out  |pcm_o - 2^(WIN_LOG2-1)|
//   loud_o     out  amp_o >= THRESH
//   valid_o    out  one-cycle strobe marking a new pcm_o/amp_o/loud_o
//   peak_o     out  decaying peak of amp_o (only with PDM_PEAK_HOLD_EN)
//
// Build option:
//   PDM_PEAK_HOLD_EN  adds peak_o: on each window, takes the new amplitude if
//                     larger, otherwise decays by one toward zero.
// ---------------------------------------------------------------------------
module pdm_mic_frontend #(
    parameter int unsigned         CLK_DIV  = 50,
    parameter int unsigned         WIN_LOG2 = 8,
    parameter logic [WIN_LOG2-1:0] THRESH   = WIN_LOG2'(64)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                m_data_i,
    output logic                m_clk_o,
    output logic                m_lrsel_o,
    output logic [WIN_LOG2:0]   pcm_o,
    output logic [WIN_LOG2-1:0] amp_o,
    output logic                loud_o,
    output logic                valid_o
`ifdef PDM_PEAK_HOLD_EN
    ,
    output logic [WIN_LOG2-1:0] peak_o
`endif
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [WIN_LOG2-1:0] SAMP_LAST = '1;
    // Mid-scale 2^(WIN_LOG2-1), in window-count width and in pcm width.
    localparam logic [WIN_LOG2-1:0] MID_W     = {1'b1, {(WIN_LOG2-1){1'b0}}};
    localparam logic [WIN_LOG2:0]   MID_P     = {1'b0, MID_W};

    logic [DIV_W-1:0]    div_cnt_q,  div_cnt_d;
    logic                m_clk_q,    m_clk_d;
    logic                sync1_q,    sync2_q;
    logic [WIN_LOG2-1:0] samp_cnt_q, samp_cnt_d;
    logic [WIN_LOG2:0]   ones_q,     ones_d;
    logic [WIN_LOG2:0]   pcm_q,      pcm_d;
    logic [WIN_LOG2-1:0] amp_q,      amp_d;
    logic                loud_q,     loud_d;
    logic                valid_q,    valid_d;

    logic                strobe;
    logic                win_close;
    logic [WIN_LOG2:0]   ones_inc;

    // Strobe sits in the last cycle of the high phase, just before the
    // falling edge; gating with en_i makes en_i win over a coincident close.
    always_comb begin
        strobe    = en_i && (div_cnt_q == DIV_LAST);
        win_close = strobe && (samp_cnt_q == SAMP_LAST);
        ones_inc  = ones_q + {{WIN_LOG2{1'b0}}, sync2_q};
    end

    always_comb begin
        div_cnt_d  = div_cnt_q;
        m_clk_d    = 1'b0;
        samp_cnt_d = samp_cnt_q;
        ones_d     = ones_q;
        pcm_d      = pcm_q;
        amp_d      = amp_q;
        loud_d     = loud_q;
        valid_d    = 1'b0;

        if (!en_i) begin
            div_cnt_d  = '0;
            samp_cnt_d = '0;
            ones_d     = '0;
        end else begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end

            if (strobe) begin
                samp_cnt_d = samp_cnt_q + WIN_LOG2'(1);
                ones_d     = ones_inc;
            end

            if (win_close) begin
                ones_d  = '0;
                pcm_d   = ones_inc;
                valid_d = 1'b1;
                // The amplitude never exceeds 2^(WIN_LOG2-1), so the
                // difference is exact when taken modulo 2^WIN_LOG2; the
                // full-width compare picks the larger operand.
                if (ones_inc >= MID_P) begin
                    amp_d = ones_inc[WIN_LOG2-1:0] - MID_W;
                end else begin
                    amp_d = MID_W - ones_inc[WIN_LOG2-1:0];
                end
                loud_d = (amp_d >= THRESH);
            end
        end

        // Decoded from the next count so m_clk_q lines up with div_cnt_q;
        // div_cnt_d is zero while disabled, which holds the clock low.
        m_clk_d = (div_cnt_d >= DIV_HALF);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q  <= '0;
            m_clk_q    <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            samp_cnt_q <= '0;
            ones_q     <= '0;
            pcm_q      <= '0;
            amp_q      <= '0;
            loud_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            m_clk_q    <= m_clk_d;
            sync1_q    <= m_data_i;
            sync2_q    <= sync1_q;
            samp_cnt_q <= samp_cnt_d;
            ones_q     <= ones_d;
            pcm_q      <= pcm_d;
            amp_q      <= amp_d;
            loud_q     <= loud_d;
            valid_q    <= valid_d;
        end
    end

`ifdef PDM_PEAK_HOLD_EN
    logic [WIN_LOG2-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (win_close) begin
            if (amp_d > peak_q) begin
                peak_d = amp_d;
            end else if (peak_q != '0) begin
                peak_d = peak_q - WIN_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_o = peak_q;
`endif

    assign m_clk_o   = m_clk_q;
    assign m_lrsel_o = 1'b0;
    assign pcm_o     = pcm_q;
    assign amp_o     = amp_q;
    assign loud_o    = loud_q;
    assign valid_o   = valid_q;

endmodule
